// File: rtl/scale_coord_gen.sv
// Scaled source-coordinate generator: walks an output raster and emits the
// matching input pixel (integer part plus 1/64 weight) under valid/ready flow control.
module scale_coord_gen #(
  parameter int INPUT_RES_WIDTH  = 11,
  parameter int OUTPUT_RES_WIDTH = 11,
  parameter int SCALE_BITS       = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inEn,
  input  logic                        iVsyn,
  input  logic [SCALE_BITS-1:0]       kX,
  input  logic [SCALE_BITS-1:0]       kY,
  input  logic [INPUT_RES_WIDTH-1:0]  xBgn,
  input  logic [INPUT_RES_WIDTH-1:0]  xEnd,
  input  logic [INPUT_RES_WIDTH-1:0]  yBgn,
  input  logic [INPUT_RES_WIDTH-1:0]  yEnd,
  input  logic [OUTPUT_RES_WIDTH-1:0] outXRes,
  input  logic [OUTPUT_RES_WIDTH-1:0] outYRes,
  input  logic                        oReady,
  output logic                        oValid,
  output logic [INPUT_RES_WIDTH-1:0]  srcX,
  output logic [INPUT_RES_WIDTH-1:0]  srcY,
  output logic [5:0]                  fracX,
  output logic [5:0]                  fracY,
  output logic                        lineEnd,
  output logic                        frameEnd,
  output logic                        busy
);

  localparam int IW = INPUT_RES_WIDTH;
  localparam int OW = OUTPUT_RES_WIDTH;
  localparam int AW = INPUT_RES_WIDTH + 7;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic                  iVsynDly_q;
  logic [SCALE_BITS-1:0] kX_q, kX_d, kY_q, kY_d;
  logic [IW-1:0]         xBgn_q, xBgn_d, xEnd_q, xEnd_d;
  logic [IW-1:0]         yBgn_q, yBgn_d, yEnd_q, yEnd_d;
  logic [OW-1:0]         outXRes_q, outXRes_d, outYRes_q, outYRes_d;
  logic [OW-1:0]         outX_q, outX_d, outY_q, outY_d;
  logic [AW-1:0]         accX_q, accX_d, accY_q, accY_d;
  logic                  valid_d;
  logic                  vsEdge, start, xfer;
  logic [IW+5:0]         mapX_d, mapY_d;
  logic                  lineEnd_d;

  // Integer/fraction split of an accumulator, pinned to the crop edge when it runs past it.
  function automatic logic [IW+5:0] mapCoord(input logic [AW-1:0] acc, input logic [IW-1:0] lim);
    logic [IW:0] intPart;
    intPart = acc[AW-1:6];
    if (intPart > {1'b0, lim})
      mapCoord = {lim, 6'd0};
    else
      mapCoord = {intPart[IW-1:0], acc[5:0]};
  endfunction

  assign vsEdge = iVsyn & ~iVsynDly_q;

  always_comb begin
    state_d   = state_q;
    valid_d   = oValid;
    kX_d      = kX_q;
    kY_d      = kY_q;
    xBgn_d    = xBgn_q;
    xEnd_d    = xEnd_q;
    yBgn_d    = yBgn_q;
    yEnd_d    = yEnd_q;
    outXRes_d = outXRes_q;
    outYRes_d = outYRes_q;
    outX_d    = outX_q;
    outY_d    = outY_q;
    accX_d    = accX_q;
    accY_d    = accY_q;
    start     = 1'b0;
    xfer      = 1'b0;

    if (!inEn) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM:  start = vsEdge;
        RUN: begin
          start = vsEdge;
          xfer  = ~vsEdge & oValid & oReady;
        end
        DONE: begin
          start = vsEdge;
          if (!vsEdge) state_d = ARM;
        end
        default: state_d = IDLE;
      endcase
    end

    if (start) begin
      state_d   = RUN;
      valid_d   = 1'b1;
      kX_d      = (kX == '0) ? SCALE_BITS'(1) : kX;
      kY_d      = (kY == '0) ? SCALE_BITS'(1) : kY;
      xBgn_d    = xBgn;
      xEnd_d    = xEnd;
      yBgn_d    = yBgn;
      yEnd_d    = yEnd;
      outXRes_d = outXRes;
      outYRes_d = outYRes;
      outX_d    = '0;
      outY_d    = '0;
      accX_d    = {1'b0, xBgn, 6'd0};
      accY_d    = {1'b0, yBgn, 6'd0};
    end else if (xfer) begin
      if (outX_q < outXRes_q) begin
        outX_d = outX_q + OW'(1);
        accX_d = accX_q + AW'(kX_q);
      end else if (outY_q < outYRes_q) begin
        outX_d = '0;
        accX_d = {1'b0, xBgn_q, 6'd0};
        outY_d = outY_q + OW'(1);
        accY_d = accY_q + AW'(kY_q);
      end else begin
        state_d = DONE;
        valid_d = 1'b0;
      end
    end

    mapX_d    = mapCoord(accX_d, xEnd_d);
    mapY_d    = mapCoord(accY_d, yEnd_d);
    lineEnd_d = (outX_d == outXRes_d);
  end

  // Outputs are recomputed from next-state values so they stay registered yet line up with the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      iVsynDly_q <= 1'b0;
      kX_q       <= '0;
      kY_q       <= '0;
      xBgn_q     <= '0;
      xEnd_q     <= '0;
      yBgn_q     <= '0;
      yEnd_q     <= '0;
      outXRes_q  <= '0;
      outYRes_q  <= '0;
      outX_q     <= '0;
      outY_q     <= '0;
      accX_q     <= '0;
      accY_q     <= '0;
      oValid     <= 1'b0;
      srcX       <= '0;
      srcY       <= '0;
      fracX      <= '0;
      fracY      <= '0;
      lineEnd    <= 1'b0;
      frameEnd   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      iVsynDly_q <= iVsyn;
      kX_q       <= kX_d;
      kY_q       <= kY_d;
      xBgn_q     <= xBgn_d;
      xEnd_q     <= xEnd_d;
      yBgn_q     <= yBgn_d;
      yEnd_q     <= yEnd_d;
      outXRes_q  <= outXRes_d;
      outYRes_q  <= outYRes_d;
      outX_q     <= outX_d;
      outY_q     <= outY_d;
      accX_q     <= accX_d;
      accY_q     <= accY_d;
      oValid     <= valid_d;
      srcX       <= mapX_d[IW+5:6];
      fracX      <= mapX_d[5:0];
      srcY       <= mapY_d[IW+5:6];
      fracY      <= mapY_d[5:0];
      lineEnd    <= lineEnd_d;
      frameEnd   <= lineEnd_d & (outY_d == outYRes_d);
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_scale_coord_gen.sv
// Randomized self-checking bench for scale_coord_gen against a per-pixel arithmetic model.
module tb_scale_coord_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inEn = 1'b0;
  logic        iVsyn = 1'b0;
  logic [7:0]  kX = '0, kY = '0;
  logic [10:0] xBgn = '0, xEnd = '0, yBgn = '0, yEnd = '0;
  logic [10:0] outXRes = '0, outYRes = '0;
  logic        oReady = 1'b0;
  logic        oValid;
  logic [10:0] srcX, srcY;
  logic [5:0]  fracX, fracY;
  logic        lineEnd, frameEnd, busy;

  int errors = 0;
  int checks = 0;

  // Parameters of the frame currently running, as the model sees them
  int pkX, pkY, pxBgn, pxEnd, pyBgn, pyEnd, pXRes, pYRes;

  wire [35:0] obs = {srcX, fracX, srcY, fracY, lineEnd, frameEnd};

  scale_coord_gen dut (
    .clk(clk), .rst(rst), .inEn(inEn), .iVsyn(iVsyn),
    .kX(kX), .kY(kY), .xBgn(xBgn), .xEnd(xEnd), .yBgn(yBgn), .yEnd(yEnd),
    .outXRes(outXRes), .outYRes(outYRes), .oReady(oReady),
    .oValid(oValid), .srcX(srcX), .srcY(srcY), .fracX(fracX), .fracY(fracY),
    .lineEnd(lineEnd), .frameEnd(frameEnd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected coordinate for raster index i, computed directly from position and step
  function automatic logic [35:0] expCoord(input int i);
    int x, y, kx, ky, ax, ay, sx, fx, sy, fy;
    logic le, fe;
    x  = i % (pXRes + 1);
    y  = i / (pXRes + 1);
    kx = (pkX == 0) ? 1 : pkX;
    ky = (pkY == 0) ? 1 : pkY;
    ax = pxBgn * 64 + x * kx;
    ay = pyBgn * 64 + y * ky;
    sx = ax / 64; fx = ax % 64;
    sy = ay / 64; fy = ay % 64;
    if (sx > pxEnd) begin sx = pxEnd; fx = 0; end
    if (sy > pyEnd) begin sy = pyEnd; fy = 0; end
    le = (x == pXRes);
    fe = le && (y == pYRes);
    return {11'(sx), 6'(fx), 11'(sy), 6'(fy), le, fe};
  endfunction

  task automatic setParams(input int kx, ky, xb, xe, yb, ye, xr, yr);
    kX = 8'(kx); kY = 8'(ky);
    xBgn = 11'(xb); xEnd = 11'(xe); yBgn = 11'(yb); yEnd = 11'(ye);
    outXRes = 11'(xr); outYRes = 11'(yr);
    pkX = kx; pkY = ky; pxBgn = xb; pxEnd = xe; pyBgn = yb; pyEnd = ye;
    pXRes = xr; pYRes = yr;
  endtask

  // Leaves the bench just before the clock edge that sees the sync rising edge
  task automatic startFrame(input int kx, ky, xb, xe, yb, ye, xr, yr);
    @(negedge clk);
    setParams(kx, ky, xb, xe, yb, ye, xr, yr);
    inEn = 1'b1;
    iVsyn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    iVsyn = 1'b1;
  endtask

  // mode 0: ready always high, 1: random ready with input scrambling, 2: ready pattern 1,0,0,1
  task automatic runFrame(input int mode);
    int total, idx, cyc, budget;
    logic rdy, prevHeld;
    logic [35:0] prevObs, e;
    total = (pXRes + 1) * (pYRes + 1);
    budget = total * 8 + 20;
    idx = 0; cyc = 0; prevHeld = 1'b0; prevObs = '0;
    while (idx < total && cyc < budget) begin
      @(negedge clk);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      cyc++;
      oReady = rdy;
      if (mode == 1) begin
        kX = 8'($urandom); kY = 8'($urandom);
        xBgn = 11'($urandom); xEnd = 11'($urandom);
        yBgn = 11'($urandom); yEnd = 11'($urandom);
        outXRes = 11'($urandom); outYRes = 11'($urandom);
      end
      if (cyc == 1) begin
        checks++;
        if (oValid !== 1'b1) begin
          errors++;
          $display("[TB] FAIL first_valid: oValid=%b required 1", oValid);
        end
      end
      if (prevHeld) begin
        checks++;
        if (oValid !== 1'b1 || obs !== prevObs) begin
          errors++;
          $display("[TB] FAIL hold idx=%0d: got v=%b %h required v=1 %h", idx, oValid, obs, prevObs);
        end
      end
      if (oValid && rdy) begin
        e = expCoord(idx);
        checks++;
        if (obs !== e) begin
          errors++;
          $display("[TB] FAIL coord idx=%0d: got sx=%0d fx=%0d sy=%0d fy=%0d le=%b fe=%b required sx=%0d fx=%0d sy=%0d fy=%0d le=%b fe=%b",
                   idx, obs[35:25], obs[24:19], obs[18:8], obs[7:2], obs[1], obs[0],
                   e[35:25], e[24:19], e[18:8], e[7:2], e[1], e[0]);
        end
        idx++;
      end
      prevHeld = oValid && !rdy;
      prevObs = obs;
    end
    checks++;
    if (idx < total) begin
      errors++;
      $display("[TB] FAIL frame_timeout: transfers=%0d required %0d", idx, total);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != total) begin
        errors++;
        $display("[TB] FAIL throughput: cycles=%0d required %0d", cyc, total);
      end
    end
    @(negedge clk);
    checks++;
    if (oValid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL frame_done: oValid=%b busy=%b required 0 1", oValid, busy);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({oValid, srcX, srcY, fracX, fracY, lineEnd, frameEnd, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b sx=%0d sy=%0d fx=%0d fy=%0d le=%b fe=%b busy=%b required all 0",
               oValid, srcX, srcY, fracX, fracY, lineEnd, frameEnd, busy);
    end
    @(negedge clk);
    iVsyn = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_en: busy=%b required 0", busy);
    end
    inEn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || oValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arm_no_fresh_edge: busy=%b oValid=%b required 1 0", busy, oValid);
    end
  endtask

  task automatic test_identity;
    startFrame(64, 64, 0, 10, 0, 10, 3, 1);
    runFrame(0);
  endtask

  task automatic test_upscale;
    startFrame(32, 64, 2, 10, 0, 10, 3, 1);
    runFrame(0);
  endtask

  task automatic test_backpressure;
    startFrame(64, 64, 0, 10, 0, 10, 3, 1);
    runFrame(2);
  endtask

  task automatic test_clamp;
    startFrame(200, 100, 0, 5, 0, 2, 3, 2);
    runFrame(0);
  endtask

  task automatic test_zero_step;
    startFrame(0, 0, 7, 20, 4, 20, 5, 2);
    runFrame(0);
  endtask

  task automatic test_restart;
    startFrame(64, 48, 3, 30, 1, 30, 3, 3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      oReady = 1'b1;
      if (k == 0) iVsyn = 1'b0;
      checks++;
      if (oValid !== 1'b1 || obs !== expCoord(k)) begin
        errors++;
        $display("[TB] FAIL restart_pre idx=%0d: got v=%b %h required v=1 %h", k, oValid, obs, expCoord(k));
      end
      if (k == 4) begin
        iVsyn = 1'b1;
        setParams(40, 64, 9, 30, 2, 30, 3, 3);
      end
    end
    runFrame(0);
  endtask

  task automatic test_abort_inen;
    startFrame(64, 64, 0, 10, 0, 10, 7, 7);
    repeat (3) begin
      @(negedge clk);
      oReady = 1'b1;
    end
    inEn = 1'b0;
    checks++;
    if (oValid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL inen_not_early: oValid=%b required 1", oValid);
    end
    @(negedge clk);
    checks++;
    if (oValid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inen_abort: oValid=%b busy=%b required 0 0", oValid, busy);
    end
  endtask

  task automatic test_abort_rst;
    startFrame(64, 64, 5, 10, 0, 10, 7, 7);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (oValid !== 1'b0 || busy !== 1'b0 || srcX !== 11'd0) begin
      errors++;
      $display("[TB] FAIL rst_abort: oValid=%b busy=%b srcX=%0d required 0 0 0", oValid, busy, srcX);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random;
    int xb, yb;
    for (int f = 0; f < 6; f++) begin
      xb = $urandom_range(0, 50);
      yb = $urandom_range(0, 50);
      startFrame($urandom_range(0, 255), $urandom_range(0, 255),
                 xb, xb + $urandom_range(0, 40), yb, yb + $urandom_range(0, 40),
                 $urandom_range(0, 7), $urandom_range(0, 4));
      runFrame(1);
    end
  endtask

  initial begin
    test_reset;
    test_identity;
    test_upscale;
    test_backpressure;
    test_clamp;
    test_zero_step;
    test_restart;
    test_abort_inen;
    test_abort_rst;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
